// File: rtl/mod_swapchain_pkg.sv
// =============================================================================
// mod_swapchain_pkg : shared types, constants and helpers for the segment
// swap controller.                                              Rev 1.0
// =============================================================================
`default_nettype none

package mod_swapchain_pkg;

  typedef enum logic [7:0] {
    TM_SYNC_IDX = 8'h00,
    TM_SYS_TIME = 8'h01,
    TM_GPIO     = 8'h02,
    TM_EXT      = 8'hF0
  } transition_mode_t;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_WAIT_SYNC = 3'd1,
    ST_WAIT_TIME = 3'd2,
    ST_WAIT_GPIO = 3'd3,
    ST_EXT_RUN   = 3'd4
  } swapchain_state_t;

  localparam logic [15:0] RepInfinite = 16'hFFFF;

  function automatic logic mode_supported(input logic [7:0] mode);
    case (mode)
      TM_SYNC_IDX, TM_SYS_TIME, TM_GPIO: mode_supported = 1'b1;
`ifdef MOD_SWAPCHAIN_EXT_TRANSITION_EN
      TM_EXT:                            mode_supported = 1'b1;
`endif
      default:                           mode_supported = 1'b0;
    endcase
  endfunction

  // EXT requests make their first swap on a loop boundary, like SYNC_IDX.
  function automatic swapchain_state_t wait_state(input logic [7:0] mode);
    case (mode)
      TM_SYS_TIME: wait_state = ST_WAIT_TIME;
      TM_GPIO:     wait_state = ST_WAIT_GPIO;
      default:     wait_state = ST_WAIT_SYNC;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_swapchain_swap_trigger.sv
// =============================================================================
// mod_swapchain_swap_trigger : per-mode swap trigger evaluation with GPIO edge
// detection and absolute-time compare.                          Rev 1.0
// =============================================================================
`default_nettype none

module mod_swapchain_swap_trigger
  import mod_swapchain_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [2:0]  i_state,
  input  logic        i_stop,
  input  logic        i_loop_end,
  input  logic [63:0] i_sys_time,
  input  logic [63:0] i_value,
  input  logic [3:0]  i_gpio_in,
  output logic        o_trigger
);

  logic [3:0] r_gpio_d;
  logic       w_time_reached;
  logic       w_gpio_rise;

  // Free-running delay so only edges that occur while waiting are seen.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gpio_d <= 4'b0000;
    end else begin
      r_gpio_d <= i_gpio_in;
    end
  end

  assign w_time_reached = (i_sys_time >= i_value);
  assign w_gpio_rise    = i_gpio_in[i_value[1:0]] & ~r_gpio_d[i_value[1:0]];

  always_comb begin
    o_trigger = 1'b0;
    case (swapchain_state_t'(i_state))
      ST_WAIT_SYNC: o_trigger = i_loop_end | i_stop;
      ST_WAIT_TIME: o_trigger = w_time_reached;
      ST_WAIT_GPIO: o_trigger = w_gpio_rise;
      default:      o_trigger = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mod_swapchain.sv
// =============================================================================
// mod_swapchain : active-segment swap FSM and repetition counter for the
// modulation/STM paths. Option macro: MOD_SWAPCHAIN_EXT_TRANSITION_EN. Rev 1.0
// =============================================================================
`default_nettype none

module mod_swapchain
  import mod_swapchain_pkg::*;
#(
  parameter  int NUM_SEGMENT = 2,
  localparam int SEG_W       = $clog2(NUM_SEGMENT)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_update_settings,
  input  logic [SEG_W-1:0] i_req_rd_segment,
  input  logic [15:0]      i_rep,
  input  logic [7:0]       i_transition_mode,
  input  logic [63:0]      i_transition_value,
  input  logic [63:0]      i_sys_time,
  input  logic [3:0]       i_gpio_in,
  input  logic             i_loop_end,
  output logic [SEG_W-1:0] o_segment,
  output logic             o_swap,
  output logic             o_stop,
  output logic             o_req_err
);

  swapchain_state_t r_state, w_state_nxt;
  logic [SEG_W-1:0] r_pend_seg, w_pend_seg_nxt;
  logic [15:0]      r_pend_rep, w_pend_rep_nxt;
  logic [63:0]      r_pend_value, w_pend_value_nxt;
  logic [15:0]      r_rep, w_rep_nxt;
  logic [15:0]      r_loop_cnt, w_cnt_nxt;
  logic [SEG_W-1:0] r_segment, w_seg_nxt;
  logic             r_swap, w_swap_nxt;
  logic             r_stop, w_stop_nxt;
  logic             r_req_err, w_req_err_nxt;
  logic             w_accept;
  logic             w_trigger;
  logic             w_req_ext;
  logic             w_ext_run;
  logic             w_pend_ext;
  logic             w_pend_ext_nxt;

`ifdef MOD_SWAPCHAIN_EXT_TRANSITION_EN
  logic r_pend_ext;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend_ext <= 1'b0;
    end else begin
      r_pend_ext <= w_pend_ext_nxt;
    end
  end

  assign w_pend_ext = r_pend_ext;
  assign w_req_ext  = (i_transition_mode == TM_EXT);
  assign w_ext_run  = (r_state == ST_EXT_RUN);
`else
  assign w_pend_ext = 1'b0;
  assign w_req_ext  = 1'b0;
  assign w_ext_run  = 1'b0;
`endif

  assign w_accept      = i_update_settings & mode_supported(i_transition_mode);
  assign w_req_err_nxt = i_update_settings & ~mode_supported(i_transition_mode);

  mod_swapchain_swap_trigger u_trigger (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_state    (r_state),
    .i_stop     (r_stop),
    .i_loop_end (i_loop_end),
    .i_sys_time (i_sys_time),
    .i_value    (r_pend_value),
    .i_gpio_in  (i_gpio_in),
    .o_trigger  (w_trigger)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_RUN;
      r_pend_seg   <= '0;
      r_pend_rep   <= RepInfinite;
      r_pend_value <= 64'd0;
      r_rep        <= RepInfinite;
      r_loop_cnt   <= 16'd0;
      r_segment    <= '0;
      r_swap       <= 1'b0;
      r_stop       <= 1'b0;
      r_req_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pend_seg   <= w_pend_seg_nxt;
      r_pend_rep   <= w_pend_rep_nxt;
      r_pend_value <= w_pend_value_nxt;
      r_rep        <= w_rep_nxt;
      r_loop_cnt   <= w_cnt_nxt;
      r_segment    <= w_seg_nxt;
      r_swap       <= w_swap_nxt;
      r_stop       <= w_stop_nxt;
      r_req_err    <= w_req_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pend_seg_nxt   = r_pend_seg;
    w_pend_rep_nxt   = r_pend_rep;
    w_pend_value_nxt = r_pend_value;
    w_pend_ext_nxt   = w_pend_ext;
    w_rep_nxt        = r_rep;
    w_cnt_nxt        = r_loop_cnt;
    w_seg_nxt        = r_segment;
    w_swap_nxt       = 1'b0;
    w_stop_nxt       = r_stop;

    // The running segment keeps counting in every state, including waits.
    if (i_loop_end && (r_rep != RepInfinite)) begin
      if (r_loop_cnt != r_rep) begin
        w_cnt_nxt = r_loop_cnt + 16'd1;
      end else if (w_ext_run) begin
        w_seg_nxt  = ~r_segment;
        w_swap_nxt = 1'b1;
        w_cnt_nxt  = 16'd0;
      end else begin
        w_stop_nxt = 1'b1;
      end
    end

    if (w_accept) begin
      if ((i_req_rd_segment == r_segment) && !w_req_ext) begin
        w_rep_nxt   = i_rep;
        w_cnt_nxt   = 16'd0;
        w_stop_nxt  = 1'b0;
        w_seg_nxt   = r_segment;
        w_swap_nxt  = 1'b0;
        w_state_nxt = ST_RUN;
      end else begin
        w_pend_seg_nxt   = i_req_rd_segment;
        w_pend_rep_nxt   = i_rep;
        w_pend_value_nxt = i_transition_value;
        w_pend_ext_nxt   = w_req_ext;
        w_state_nxt      = wait_state(i_transition_mode);
      end
    end else if (w_trigger) begin
      w_seg_nxt   = r_pend_seg;
      w_swap_nxt  = 1'b1;
      w_rep_nxt   = r_pend_rep;
      w_cnt_nxt   = 16'd0;
      w_stop_nxt  = 1'b0;
      w_state_nxt = w_pend_ext ? ST_EXT_RUN : ST_RUN;
    end
  end

  assign o_segment = r_segment;
  assign o_swap    = r_swap;
  assign o_stop    = r_stop;
  assign o_req_err = r_req_err;

endmodule

`default_nettype wire

// File: tb/tb_mod_swapchain.sv
// =============================================================================
// tb_mod_swapchain : directed self-checking bench for mod_swapchain.
// Observed vector is {segment, swap, stop, req_err}.             Rev 1.0
// =============================================================================
`default_nettype none

module tb_mod_swapchain;
  import mod_swapchain_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        update = 1'b0;
  logic        req_seg = 1'b0;
  logic [15:0] rep = 16'd0;
  logic [7:0]  mode = 8'd0;
  logic [63:0] value = 64'd0;
  logic [63:0] sys_time = 64'd0;
  logic [3:0]  gpio = 4'd0;
  logic        loop_end = 1'b0;
  logic        o_segment, o_swap, o_stop, o_req_err;
  logic [3:0]  obs;

  int n_cmp = 0;
  int n_err = 0;

  assign obs = {o_segment, o_swap, o_stop, o_req_err};

  mod_swapchain dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_update_settings  (update),
    .i_req_rd_segment   (req_seg),
    .i_rep              (rep),
    .i_transition_mode  (mode),
    .i_transition_value (value),
    .i_sys_time         (sys_time),
    .i_gpio_in          (gpio),
    .i_loop_end         (loop_end),
    .o_segment          (o_segment),
    .o_swap             (o_swap),
    .o_stop             (o_stop),
    .o_req_err          (o_req_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic s, input logic [15:0] r, input logic [7:0] m,
                         input logic [63:0] v);
    req_seg = s; rep = r; mode = m; value = v; update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  task automatic pulse_loop_end();
    loop_end = 1'b1;
    tick();
    loop_end = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL reset_outputs: got %b want %b", obs, 4'b0000); end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pulse_loop_end();
      n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL reset_inf_rep[%0d]: got %b want %b", i, obs, 4'b0000); end
    end
  endtask

  task automatic test_sync();
    request(1'b1, 16'd1, TM_SYNC_IDX, 64'd0);
    n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL sync_req_cycle: got %b want %b", obs, 4'b0000); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL sync_wait[%0d]: got %b want %b", i, obs, 4'b0000); end
    end
    pulse_loop_end();
    n_cmp++; if (obs !== 4'b1100) begin n_err++; $display("FAIL sync_swap: got %b want %b", obs, 4'b1100); end
    tick();
    n_cmp++; if (obs !== 4'b1000) begin n_err++; $display("FAIL sync_swap_pulse: got %b want %b", obs, 4'b1000); end
    pulse_loop_end();
    n_cmp++; if (obs !== 4'b1000) begin n_err++; $display("FAIL sync_loop1: got %b want %b", obs, 4'b1000); end
    pulse_loop_end();
    n_cmp++; if (obs !== 4'b1010) begin n_err++; $display("FAIL sync_stop: got %b want %b", obs, 4'b1010); end
    // STOP already high triggers a SYNC_IDX request at once: 2-cycle latency.
    request(1'b0, 16'hFFFF, TM_SYNC_IDX, 64'd0);
    n_cmp++; if (obs !== 4'b1010) begin n_err++; $display("FAIL stop_trig_req: got %b want %b", obs, 4'b1010); end
    tick();
    n_cmp++; if (obs !== 4'b0100) begin n_err++; $display("FAIL stop_trig_swap: got %b want %b", obs, 4'b0100); end
    // LOOP_END coincident with the strobe belongs to the old context.
    loop_end = 1'b1;
    request(1'b1, 16'd0, TM_SYNC_IDX, 64'd0);
    loop_end = 1'b0;
    n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL same_cycle_le: got %b want %b", obs, 4'b0000); end
    tick();
    n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL same_cycle_le_next: got %b want %b", obs, 4'b0000); end
    pulse_loop_end();
    n_cmp++; if (obs !== 4'b1100) begin n_err++; $display("FAIL same_cycle_le_swap: got %b want %b", obs, 4'b1100); end
  endtask

  task automatic test_sys_time();
    logic [63:0] v;
    logic [3:0]  exp;
    sys_time = 64'd989;
    request(1'b0, 16'hFFFF, TM_SYS_TIME, 64'd1000);
    n_cmp++; if (obs !== 4'b1000) begin n_err++; $display("FAIL time_req: got %b want %b", obs, 4'b1000); end
    for (int i = 0; i < 15; i++) begin
      v = 64'd990 + 64'(i);
      sys_time = v;
      tick();
      exp = {(v >= 64'd1000) ? 1'b0 : 1'b1, (v == 64'd1000), 2'b00};
      n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL time_ramp[%0d]: got %b want %b", v, obs, exp); end
    end
    request(1'b1, 16'hFFFF, TM_SYS_TIME, 64'd5);
    n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL time_past_req: got %b want %b", obs, 4'b0000); end
    tick();
    n_cmp++; if (obs !== 4'b1100) begin n_err++; $display("FAIL time_past_swap: got %b want %b", obs, 4'b1100); end
  endtask

  task automatic test_gpio();
    gpio = 4'b0100;
    tick();
    request(1'b0, 16'hFFFF, TM_GPIO, 64'd2);
    n_cmp++; if (obs !== 4'b1000) begin n_err++; $display("FAIL gpio_req: got %b want %b", obs, 4'b1000); end
    tick();
    n_cmp++; if (obs !== 4'b1000) begin n_err++; $display("FAIL gpio_held_high: got %b want %b", obs, 4'b1000); end
    gpio = 4'b0000;
    tick();
    n_cmp++; if (obs !== 4'b1000) begin n_err++; $display("FAIL gpio_low: got %b want %b", obs, 4'b1000); end
    gpio = 4'b0001;
    tick();
    n_cmp++; if (obs !== 4'b1000) begin n_err++; $display("FAIL gpio_other_pin: got %b want %b", obs, 4'b1000); end
    gpio = 4'b0101;
    tick();
    n_cmp++; if (obs !== 4'b0100) begin n_err++; $display("FAIL gpio_edge_swap: got %b want %b", obs, 4'b0100); end
    gpio = 4'b0000;
    tick();
    gpio = 4'b0100;
    tick();
    n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL gpio_single_swap: got %b want %b", obs, 4'b0000); end
    gpio = 4'b0000;
  endtask

  task automatic test_replace();
    request(1'b1, 16'd5, TM_SYNC_IDX, 64'd0);
    request(1'b0, 16'd0, TM_SYNC_IDX, 64'd0);
    n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL replace_req: got %b want %b", obs, 4'b0000); end
    tick();
    pulse_loop_end();
    n_cmp++; if (obs !== 4'b0010) begin n_err++; $display("FAIL replace_stop: got %b want %b", obs, 4'b0010); end
  endtask

  task automatic test_ext();
    request(1'b0, 16'hFFFF, TM_SYNC_IDX, 64'd0);
    n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL ext_prep: got %b want %b", obs, 4'b0000); end
`ifdef MOD_SWAPCHAIN_EXT_TRANSITION_EN
    request(1'b1, 16'd0, TM_EXT, 64'd0);
    tick();
    n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL ext_wait: got %b want %b", obs, 4'b0000); end
    pulse_loop_end();
    n_cmp++; if (obs !== 4'b1100) begin n_err++; $display("FAIL ext_first_swap: got %b want %b", obs, 4'b1100); end
    tick();
    n_cmp++; if (obs !== 4'b1000) begin n_err++; $display("FAIL ext_idle: got %b want %b", obs, 4'b1000); end
    pulse_loop_end();
    n_cmp++; if (obs !== 4'b0100) begin n_err++; $display("FAIL ext_alt1: got %b want %b", obs, 4'b0100); end
    pulse_loop_end();
    n_cmp++; if (obs !== 4'b1100) begin n_err++; $display("FAIL ext_alt2: got %b want %b", obs, 4'b1100); end
    pulse_loop_end();
    n_cmp++; if (obs !== 4'b0100) begin n_err++; $display("FAIL ext_alt3: got %b want %b", obs, 4'b0100); end
    request(1'b0, 16'hFFFF, TM_SYNC_IDX, 64'd0);
    pulse_loop_end();
    n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL ext_exit: got %b want %b", obs, 4'b0000); end
`else
    request(1'b1, 16'd0, 8'hF0, 64'd0);
    n_cmp++; if (obs !== 4'b0001) begin n_err++; $display("FAIL ext_unsupported: got %b want %b", obs, 4'b0001); end
    tick();
    n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL ext_err_pulse: got %b want %b", obs, 4'b0000); end
    pulse_loop_end();
    n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL ext_no_swap: got %b want %b", obs, 4'b0000); end
`endif
  endtask

  task automatic test_req_err();
    request(1'b1, 16'd0, 8'h07, 64'd0);
    n_cmp++; if (obs !== 4'b0001) begin n_err++; $display("FAIL req_err_pulse: got %b want %b", obs, 4'b0001); end
    tick();
    n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL req_err_clear: got %b want %b", obs, 4'b0000); end
    pulse_loop_end();
    n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL req_err_no_effect: got %b want %b", obs, 4'b0000); end
  endtask

  task automatic test_reset_async();
    request(1'b1, 16'hFFFF, TM_SYNC_IDX, 64'd0);
    pulse_loop_end();
    n_cmp++; if (obs !== 4'b1100) begin n_err++; $display("FAIL rst_prep_swap: got %b want %b", obs, 4'b1100); end
    request(1'b0, 16'hFFFF, TM_GPIO, 64'd1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL rst_async: got %b want %b", obs, 4'b0000); end
    @(posedge clk); #1 rst_n = 1'b1;
    gpio = 4'b0010;
    tick();
    n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL rst_pending_lost: got %b want %b", obs, 4'b0000); end
    tick();
    n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL rst_quiet: got %b want %b", obs, 4'b0000); end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_sys_time();
    test_gpio();
    test_replace();
    test_ext();
    test_req_err();
    test_reset_async();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
